debounce_bank: RTL

// Multi-channel button debouncer with event outputs. Each channel has its own

---
 rtl/debounce_bank.sv | 130 +++++++++++++
 1 files changed

// File: rtl/debounce_bank.sv
// Multi-channel debouncer: synchroniser + saturating up/down integrator per channel, with press/release/hold pulses.
// Latency: out follows a steady input change after n+sync edges; press/rel coincide with out; hold at press+long (+rep...).
// No backpressure: free-running, every channel is evaluated every cycle.
//
// Ports:
//   clk   - clock, all logic on the rising edge
//   rst   - synchronous reset, active high
//   in    - raw asynchronous inputs, one bit per channel
//   out   - debounced level per channel
//   press - one-cycle pulse coincident with out rising
//   rel   - one-cycle pulse coincident with out falling
//   hold  - one-cycle long-press / auto-repeat pulse
module debounce_bank #(
    parameter int ch   = 4,
    parameter int n    = 1024,
    parameter int sync = 2,
    parameter int long = 0,
    parameter int rep  = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [ch-1:0] in,
    output logic [ch-1:0] out,
    output logic [ch-1:0] press,
    output logic [ch-1:0] rel,
    output logic [ch-1:0] hold
);

    localparam int            CW   = (n > 1) ? $clog2(n) : 1;
    localparam logic [CW-1:0] CMAX = CW'(n - 1);

    for (genvar i = 0; i < ch; i++) begin : g_ch
        logic          s;
        logic [CW-1:0] ctr;
        logic          at_top;
        logic          at_bot;
        logic          out_q;
        logic          press_q;
        logic          rel_q;

        if (sync == 0) begin : g_nosync
            assign s = in[i];
        end else begin : g_sync
            logic [sync-1:0] sr;
            // Shift-left form keeps this valid for a single stage too.
            always_ff @(posedge clk) begin
                if (rst) begin
                    sr <= '0;
                end else begin
                    sr <= (sr << 1) | (sync)'(in[i]);
                end
            end
            assign s = sr[sync-1];
        end

        assign at_top = (ctr == CMAX);
        assign at_bot = (ctr == '0);

        // Level decisions use the pre-edge counter, so the out transition and
        // its press/rel pulse land on the same edge. Between the rails out
        // holds its value, which is what rejects short pulses.
        always_ff @(posedge clk) begin
            if (rst) begin
                ctr     <= '0;
                out_q   <= 1'b0;
                press_q <= 1'b0;
                rel_q   <= 1'b0;
            end else begin
                if (s && !at_top) begin
                    ctr <= ctr + 1'b1;
                end else if (!s && !at_bot) begin
                    ctr <= ctr - 1'b1;
                end
                if (at_top) begin
                    out_q <= 1'b1;
                end else if (at_bot) begin
                    out_q <= 1'b0;
                end
                press_q <= at_top & ~out_q;
                rel_q   <= at_bot & out_q;
            end
        end

        assign out[i]   = out_q;
        assign press[i] = press_q;
        assign rel[i]   = rel_q;

        if (long > 0) begin : g_hold
            localparam int            HW     = (long > 1) ? $clog2(long + 1) : 1;
            localparam logic [HW-1:0] HIT    = HW'(long - 1);
            localparam logic [HW-1:0] SAT    = HW'(long);
            localparam logic [HW-1:0] RELOAD = HW'(long - rep);

            logic [HW-1:0] hc;
            logic          hold_q;
            logic          stay_high;

            // True only when out is 1 before this edge and is not falling on
            // it; covers "out is or becomes 0" and the press edge in one term,
            // and guarantees hold never coincides with rel.
            assign stay_high = out_q & ~at_bot;

            // hc counts edges since press; the edge on which it would reach
            // long is the hold edge, and the counter jumps back so that the
            // next hit is rep edges later (or parks at long when rep is 0).
            always_ff @(posedge clk) begin
                if (rst) begin
                    hc     <= '0;
                    hold_q <= 1'b0;
                end else if (!stay_high) begin
                    hc     <= '0;
                    hold_q <= 1'b0;
                end else if (hc == HIT) begin
                    hold_q <= 1'b1;
                    hc     <= (rep > 0) ? RELOAD : SAT;
                end else begin
                    hold_q <= 1'b0;
                    if (hc != SAT) begin
                        hc <= hc + 1'b1;
                    end
                end
            end

            assign hold[i] = hold_q;
        end else begin : g_nohold
            assign hold[i] = 1'b0;
        end
    end

endmodule
